// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU sequencer.
// Flag vectors are ordered {arith, logic, cmp, shift}.
package alu_pkg;

    localparam int unsigned FUNC_W = 4;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLG_ARITH = 3;
    localparam int unsigned FLG_LOGIC = 2;
    localparam int unsigned FLG_CMP   = 1;
    localparam int unsigned FLG_SHIFT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way request arbiter. Build with ALU_ARB_RR_EN defined for round-robin
// (owns the `last` pointer); otherwise requester 0 wins every tie.
module alu_rr_arb (
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic pick;

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        // On a tie the requester that did not win last time is served.
        pick   = valid[1] & (~valid[0] | ~last_q);
        last_d = last_q;
        if (enable && (|valid)) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        pick = valid[1] & ~valid[0];
    end
`endif

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            grant = pick ? 2'b10 : {1'b0, valid[0]};
        end
        grant_idx = pick;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester sequencer in front of a registered ALU with a tagged response
// channel. ALU_ARB_RR_EN selects round-robin tie breaking in alu_rr_arb.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [FUNC_W-1:0] req1_func,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              busy
);

    alu_arb_state_t    state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, data_q, data_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              id_q, id_d, rv_q, rv_d;
    logic [1:0]        grant;
    logic              grant_idx;
    logic              arb_en;

    // Grants are offered only in IDLE and never while reset is asserted.
    assign arb_en = (state_q == IDLE) && rst_n;

    alu_rr_arb u_arb (
`ifdef ALU_ARB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .valid     ({req1_valid, req0_valid}),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        func_d  = func_q;
        id_d    = id_q;
        data_d  = data_q;
        flags_d = flags_q;
        rv_d    = rv_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    a_d     = grant_idx ? req1_a    : req0_a;
                    b_d     = grant_idx ? req1_b    : req0_b;
                    func_d  = grant_idx ? req1_func : req0_func;
                    id_d    = grant_idx;
                    cnt_d   = 3'(ALU_LAT);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 3'd0) begin
                    data_d  = alu_out;
                    flags_d = alu_flags;
                    rv_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
            id_q    <= id_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            rv_q    <= rv_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp_valid  = rv_q;
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_flags  = flags_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_func   = func_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter with a behavioural ALU and a transaction-level
// reference model; honours ALU_ARB_RR_EN for the expected tie-break policy.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ALU_LAT = 1;

    typedef struct packed {
        logic        id;
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_func = '0, req1_func = '0;
    logic        rsp_ready = 1'b0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [15:0] rsp_data, alu_a, alu_b, alu_out;
    logic [3:0]  rsp_flags, alu_func, alu_flags;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_out(alu_out), .alu_flags(alu_flags), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural ALU: {flags, result}, flags ordered {arith, logic, cmp, shift}.
    function automatic logic [19:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
        logic [15:0] r;
        logic [3:0]  fl;
        case (f)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  r = a << b[3:0];
            4'd7:  r = a >> b[3:0];
            4'd8:  r = {15'd0, a < b};
            4'd9:  r = {15'd0, a == b};
            4'd10: r = a + 16'd1;
            4'd11: r = a - 16'd1;
            4'd12: r = a * b;
            4'd13: r = ~(a & b);
            4'd14: r = a;
            default: r = b;
        endcase
        fl = '0;
        fl[FLG_ARITH] = (f <= 4'd1) || (f >= 4'd10 && f <= 4'd12);
        fl[FLG_LOGIC] = (f >= 4'd2 && f <= 4'd5) || (f == 4'd13);
        fl[FLG_CMP]   = (f == 4'd8 || f == 4'd9) && r[0];
        fl[FLG_SHIFT] = (f == 4'd6 || f == 4'd7);
        return {fl, r};
    endfunction

    logic [19:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= ref_alu(alu_a, alu_b, alu_func);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_out   = alu_pipe[ALU_LAT-1][15:0];
    assign alu_flags = alu_pipe[ALU_LAT-1][19:16];

    // Requesters: each holds valid and payload until its op is accepted.
    op_t q0[$], q1[$];
    logic pop0 = 1'b0, pop1 = 1'b0;
    int   rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        if (pop0 && q0.size() > 0) q0.delete(0);
        if (pop1 && q1.size() > 0) q1.delete(0);
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        if (q0.size() > 0) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_func = q0[0].f; end
        if (q1.size() > 0) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_func = q1[0].f; end
        rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    // Reference model: one op in flight, response due ALU_LAT+1 edges after accept.
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mon_en = 1'b0;
    logic        m_inflight = 1'b0;
    int          m_acc_cyc = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [3:0]  m_func = '0;
`ifdef ALU_ARB_RR_EN
    logic        m_last = 1'b1;
`endif
    op_t         m_q[$];
    logic        grant_log[$];
    logic [1:0]  v, exp_gnt;
    logic        w, exp_rv;
    logic [19:0] exp_res;
    op_t         t;

    always @(negedge clk) begin
        if (mon_en) begin
            v = {req1_valid, req0_valid};
`ifdef ALU_ARB_RR_EN
            w = (v == 2'b11) ? ~m_last : v[1];
`else
            w = ~v[0];
`endif
            exp_gnt = (rst_n && !m_inflight && v != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
            exp_rv  = m_inflight && (cyc >= m_acc_cyc + int'(ALU_LAT) + 1);
            check("ready", 64'({req1_ready, req0_ready}), 64'(exp_gnt));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("busy", 64'(busy), 64'(m_inflight));
            check("alu_inputs", 64'({alu_func, alu_a, alu_b}), 64'({m_func, m_a, m_b}));
            if (exp_rv && m_q.size() > 0) begin
                exp_res = ref_alu(m_q[0].a, m_q[0].b, m_q[0].f);
                check("rsp_id", 64'(rsp_id), 64'(m_q[0].id));
                check("rsp_data", 64'(rsp_data), 64'(exp_res[15:0]));
                check("rsp_flags", 64'(rsp_flags), 64'(exp_res[19:16]));
            end
            if (!rst_n) begin
                m_inflight = 1'b0;
                m_q.delete();
                m_a = '0; m_b = '0; m_func = '0;
`ifdef ALU_ARB_RR_EN
                m_last = 1'b1;
`endif
            end else if (exp_rv && rsp_ready) begin
                if (m_q.size() > 0) m_q.delete(0);
                m_inflight = 1'b0;
            end else if (exp_gnt != 2'b00) begin
                t.id = w;
                t.a  = w ? req1_a : req0_a;
                t.b  = w ? req1_b : req0_b;
                t.f  = w ? req1_func : req0_func;
                m_q.push_back(t);
                m_a = t.a; m_b = t.b; m_func = t.f;
                m_inflight = 1'b1;
                m_acc_cyc  = cyc + 1;
`ifdef ALU_ARB_RR_EN
                m_last = w;
`endif
                grant_log.push_back(w);
            end
        end
        pop0 = req0_valid && req0_ready;
        pop1 = req1_valid && req1_ready;
    end

    task automatic drain(input int budget);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !m_inflight) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 64'(q0.size() == 0 && q1.size() == 0 && !m_inflight), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0]  g4;
    logic [19:0] bp_exp;
    int          k;
    logic        hit;

    initial begin
        // Reset held for three cycles while req0 is pending.
        q0.push_back('{id: 1'b0, f: 4'h0, a: 16'd5, b: 16'd5});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mon_en = 1'b1;
            check("rst_outputs", 64'({rsp_valid, rsp_data, rsp_flags, rsp_id,
                                      alu_a, alu_b, alu_func, busy}), 64'd0);
            check("rst_req0_ready", 64'(req0_ready), 64'd0);
        end
        @(posedge clk); #1; rst_n = 1'b1;

        // Single op (5,5,add) from req0.
        rdy_mode = 1;
        drain(100);

        // Contention from a fresh reset: both requesters always valid.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{id: 1'b0, f: 4'(i), a: 16'd1, b: 16'(i + 3)});
            q1.push_back('{id: 1'b1, f: 4'(i), a: 16'd2, b: 16'(i + 7)});
        end
        drain(300);
        check("grant_count", 64'(grant_log.size()), 64'd8);
        if (grant_log.size() >= 4) begin
            g4 = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
`ifdef ALU_ARB_RR_EN
            check("grant_order", 64'(g4), 64'(4'b0101));
`else
            check("grant_order", 64'(g4), 64'(4'b0000));
`endif
        end

        // Backpressure: consumer stalls for ten cycles after the response appears.
        rdy_mode = 0;
        q0.push_back('{id: 1'b0, f: 4'h3, a: 16'h1234, b: 16'h0F0F});
        q1.push_back('{id: 1'b1, f: 4'h1, a: 16'h00FF, b: 16'h0001});
        k = 0;
        while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
        check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        bp_exp = ref_alu(16'h1234, 16'h0F0F, 4'h3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({rsp_valid, rsp_id, rsp_flags, rsp_data}),
                  64'({1'b1, 1'b0, bp_exp[19:16], bp_exp[15:0]}));
            check("bp_ready", 64'({req1_ready, req0_ready}), 64'd0);
        end
        rdy_mode = 1;
        drain(200);

        // Function sweep from req1.
        for (int f = 0; f < 16; f++) q1.push_back('{id: 1'b1, f: 4'(f), a: 16'd5, b: 16'd5});
        drain(400);

        // Reset pulse while the op is executing.
        q0.push_back('{id: 1'b0, f: 4'h4, a: 16'h00AA, b: 16'h0055});
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1;
            if (busy && !rsp_valid) hit = 1'b1;
        end
        check("midrst_exec_seen", 64'(hit), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        q0.push_back('{id: 1'b0, f: 4'hC, a: 16'h0013, b: 16'h0021});
        drain(100);

        // Random traffic with random consumer backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0)
                q0.push_back('{id: 1'b0, f: 4'($urandom), a: 16'($urandom), b: 16'($urandom)});
            else
                q1.push_back('{id: 1'b1, f: 4'($urandom), a: 16'($urandom), b: 16'($urandom)});
        end
        drain(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester sequencer that shares one registered 16-bit ALU. Accepts operand/function requests over valid/ready handshakes and arbitrates between them. Drives the ALU's `a`/`b`/`alu_func` inputs and waits out the ALU latency. Returns `alu_out` plus the four ALU flags on a single tagged response channel. Sits between the instruction/issue logic and the `alu` instance; the ALU itself is unchanged.

## Interface
- `WIDTH`, 16, operand and result width.
- `ALU_LAT`, 1, ALU clock latency from input sampling edge to valid `alu_out` (legal range 1..7).
- `clk` in 1: clock, all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_valid` / `req1_valid` in 1: requester n has an operation.
- `req0_ready` / `req1_ready` out 1: operation accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in WIDTH: operands.
- `req0_func` / `req1_func` in 4: ALU function code, passed through unmodified.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes response.
- `rsp_id` out 1: requester index of response.
- `rsp_data` out WIDTH: captured `alu_out`.
- `rsp_flags` out 4: captured flags, bit order {arith, logic, cmp, shift}.
- `alu_a`, `alu_b` out WIDTH: to ALU `a`, `b`.
- `alu_func` out 4: to ALU `alu_func`.
- `alu_out` in WIDTH: from ALU.
- `alu_flags` in 4: {arith_flag, logic_flag, cmp_flag, shift_flag} from ALU.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `reqN_valid`, pick a winner and assert only its `reqN_ready` (combinational, IDLE only).
  - On that edge, load the winner's a/b/func into `alu_a`/`alu_b`/`alu_func`, record `rsp_id`, load `cnt=ALU_LAT`, and go to EXEC.
- **EXEC**
  - `cnt` decrements each cycle.
  - On the edge where `cnt==0`, capture `alu_out`→`rsp_data` and `alu_flags`→`rsp_flags`, set `rsp_valid`, and go to RESP.
- **RESP**
  - `rsp_valid`, `rsp_data`, `rsp_flags`, `rsp_id` are held stable until `rsp_valid&&rsp_ready`.
  - On that edge: clear `rsp_valid`, go to IDLE.
  - No accept in the same cycle as a response handshake.
- **Arbitration**
  - Only one valid: it wins.
  - Both valid: behaviour per Configuration.
  - The loser sees `ready=0` and must hold its valid and payload.
- `alu_a`/`alu_b`/`alu_func` hold their last issued values outside EXEC and never change during EXEC.
- `req*_ready` is always 0 in EXEC and RESP. Requests that arrive while busy wait.
- **Reset mid-operation**: any state returns to IDLE on the next edge. The in-flight op is discarded with no response. `rsp_valid` drops.
- **Reset values**: `rsp_valid`=0, `rsp_data`=0, `rsp_flags`=0, `rsp_id`=0, `alu_a`=0, `alu_b`=0, `alu_func`=4'b0000, `busy`=0, `req*_ready`=0, round-robin pointer `last`=1.

## Timing
- Accept edge E0.
- The ALU samples the new inputs at E1.
- `rsp_valid` rises at edge E(ALU_LAT+1). With the default of 1, that is 2 edges after accept.
- The earliest next accept is in the cycle after the response handshake. Minimum issue period is ALU_LAT+3 cycles with `rsp_ready` tied high.
- `req*_ready` depends combinationally on `req*_valid` and state only, never on `rsp_ready`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin.
  - When both are valid, the grant goes to `!last`.
  - `last` updates to the winner's index on every accept.
  - The first contested grant after reset goes to requester 0.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins a tie. The `last` register is not built.

## Structure
- Shared package `alu_pkg` holds:
  - `FUNC_W`=4 and `FLAG_W`=4;
  - flag bit index constants `FLG_ARITH`=3, `FLG_LOGIC`=2, `FLG_CMP`=1, `FLG_SHIFT`=0;
  - FSM state typedef `alu_arb_state_t` (IDLE, EXEC, RESP).
- One sub-module `alu_rr_arb`: a 2-way arbiter with inputs valid[1:0] and enable, outputs grant[1:0] and grant_idx. It owns `last` and the `ALU_ARB_RR_EN` switch.
- The FSM, counter and capture registers live in the top.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with `req0_valid`=1. Required: all outputs at their reset values and `req0_ready`=0 throughout.
- **Single op**: req0 a=5, b=5, func=4'h0, `rsp_ready`=1, ALU_LAT=1.
  - Accept at E0, `rsp_valid` at E2.
  - `rsp_data`/`rsp_flags` match the ALU model for (5,5,0).
  - `rsp_id`=0, then back in IDLE.
- **Contention, RR on**: both valid continuously, req0 a=1, req1 a=2. Required: grants alternate 0,1,0,1 and `rsp_id` alternates to match. With the macro off: four grants all to 0, and req1 starved.
- **Backpressure**: `rsp_ready`=0 for 10 cycles after `rsp_valid`. Required: response fields stay stable and `req*_ready` stays 0. Handshake on the first `rsp_ready`=1, then IDLE.
- **Function sweep**: req1 issues all funcs 0..15 with a=5, b=5. Required: 16 responses in order, each equal to the model, and `alu_func` held constant during each EXEC.
- **Reset mid-op**: assert `rst_n`=0 in EXEC for 1 cycle. Required: no `rsp_valid` ever for that op, and the next request gets a normal response.
